// File: rtl/rf_pkg.sv
// Shared constants and types for the regfile write-back scoreboard slice.
package rf_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN_DEF   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic                valid;
        reg_addr_t           addr;
        logic [XLEN_DEF-1:0] data;
    } rf_wr_req_t;

endpackage

// File: rtl/rf_wb_arbiter.sv
// Regfile write-port mux (WB has absolute priority) plus LU starvation counter.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned XLEN         = XLEN_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wb_valid,
    input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
    input  logic [XLEN-1:0]       i_wb_rd_data,
    input  logic                  i_lu_valid,
    input  logic [REG_ADDR_W-1:0] i_lu_rd_addr,
    input  logic [XLEN-1:0]       i_lu_rd_data,
    output logic                  o_lu_grant,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [XLEN-1:0]       o_rd_data,
    output logic                  o_rd_wren,
    output logic                  o_throttle
);

    localparam logic [3:0] LimitCnt = 4'(STARVE_LIMIT);

    logic       wb_eff;
    logic [3:0] starve_cnt_q, starve_cnt_d;

    // A WB write to x0 is a no-op, so it does not claim the port.
    assign wb_eff = i_wb_valid && (i_wb_rd_addr != '0);

    always_comb begin
        o_lu_grant = 1'b0;
        o_rd_wren  = 1'b0;
        o_rd_addr  = '0;
        o_rd_data  = '0;
        if (wb_eff) begin
            o_rd_wren = 1'b1;
            o_rd_addr = i_wb_rd_addr;
            o_rd_data = i_wb_rd_data;
        end else if (i_lu_valid) begin
            o_lu_grant = 1'b1;
            o_rd_wren  = (i_lu_rd_addr != '0);
            o_rd_addr  = i_lu_rd_addr;
            o_rd_data  = i_lu_rd_data;
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (i_lu_valid && !o_lu_grant) begin
            starve_cnt_d = (starve_cnt_q == LimitCnt) ? starve_cnt_q : starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign o_throttle = (starve_cnt_q == LimitCnt);

endmodule

// File: rtl/rf_wb_scoreboard.sv
// Pending-register scoreboard, issue hazard stall and write-port control.
// Optional macro RF_SB_CLEAR_BYPASS_EN lets a dependent issue in the LU grant cycle.
module rf_wb_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned XLEN         = XLEN_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_issue_valid,
    input  logic [4:0]      i_issue_rs1_addr,
    input  logic [4:0]      i_issue_rs2_addr,
    input  logic            i_issue_rs1_used,
    input  logic            i_issue_rs2_used,
    input  logic [4:0]      i_issue_rd_addr,
    input  logic            i_issue_rd_wren,
    input  logic            i_issue_long,
    output logic            o_issue_stall,
    input  logic            i_wb_valid,
    input  logic [4:0]      i_wb_rd_addr,
    input  logic [XLEN-1:0] i_wb_rd_data,
    input  logic            i_lu_valid,
    input  logic [4:0]      i_lu_rd_addr,
    input  logic [XLEN-1:0] i_lu_rd_data,
    output logic            o_lu_ready,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_rd_wren,
    output logic [31:0]     o_pending,
    output logic            o_err
);

    logic                lu_grant;
    logic                throttle;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] hazard_view;
    logic [NUM_REGS-1:0] set_mask, clr_mask;
    logic                err_q, err_d;
    logic                hazard;

    rf_wb_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .XLEN        (XLEN)
    ) u_arbiter (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_wb_valid  (i_wb_valid),
        .i_wb_rd_addr(i_wb_rd_addr),
        .i_wb_rd_data(i_wb_rd_data),
        .i_lu_valid  (i_lu_valid),
        .i_lu_rd_addr(i_lu_rd_addr),
        .i_lu_rd_data(i_lu_rd_data),
        .o_lu_grant  (lu_grant),
        .o_rd_addr   (o_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_rd_wren   (o_rd_wren),
        .o_throttle  (throttle)
    );

    assign o_lu_ready = lu_grant;
    assign clr_mask   = lu_grant ? (NUM_REGS'(1) << i_lu_rd_addr) : '0;

`ifdef RF_SB_CLEAR_BYPASS_EN
    // Regfile forwards the same-cycle write, so the retiring register is already safe to read.
    assign hazard_view = pending_q & ~clr_mask;
`else
    assign hazard_view = pending_q;
`endif

    assign hazard = (i_issue_rs1_used && hazard_view[i_issue_rs1_addr]) ||
                    (i_issue_rs2_used && hazard_view[i_issue_rs2_addr]) ||
                    (i_issue_rd_wren  && hazard_view[i_issue_rd_addr]);

    // The throttle holds decode regardless of hazards so the pipeline drains into a WB bubble.
    assign o_issue_stall = throttle || (i_issue_valid && hazard);

    always_comb begin
        set_mask = '0;
        if (i_issue_valid && !o_issue_stall && i_issue_long && i_issue_rd_wren &&
            (i_issue_rd_addr != '0)) begin
            set_mask = NUM_REGS'(1) << i_issue_rd_addr;
        end
        pending_d    = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
        err_d        = err_q ||
                       (lu_grant && (i_lu_rd_addr != '0) && !pending_q[i_lu_rd_addr]);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign o_pending = pending_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed self-checking bench for rf_wb_scoreboard (STARVE_LIMIT=4).
module tb_rf_wb_scoreboard;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_issue_valid;
    logic [4:0]  i_issue_rs1_addr, i_issue_rs2_addr, i_issue_rd_addr;
    logic        i_issue_rs1_used, i_issue_rs2_used, i_issue_rd_wren, i_issue_long;
    logic        o_issue_stall;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd_addr;
    logic [31:0] i_wb_rd_data;
    logic        i_lu_valid;
    logic [4:0]  i_lu_rd_addr;
    logic [31:0] i_lu_rd_data;
    logic        o_lu_ready;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_rd_wren;
    logic [31:0] o_pending;
    logic        o_err;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    rf_wb_scoreboard #(
        .STARVE_LIMIT(4),
        .XLEN        (32)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_issue_valid   (i_issue_valid),
        .i_issue_rs1_addr(i_issue_rs1_addr),
        .i_issue_rs2_addr(i_issue_rs2_addr),
        .i_issue_rs1_used(i_issue_rs1_used),
        .i_issue_rs2_used(i_issue_rs2_used),
        .i_issue_rd_addr (i_issue_rd_addr),
        .i_issue_rd_wren (i_issue_rd_wren),
        .i_issue_long    (i_issue_long),
        .o_issue_stall   (o_issue_stall),
        .i_wb_valid      (i_wb_valid),
        .i_wb_rd_addr    (i_wb_rd_addr),
        .i_wb_rd_data    (i_wb_rd_data),
        .i_lu_valid      (i_lu_valid),
        .i_lu_rd_addr    (i_lu_rd_addr),
        .i_lu_rd_data    (i_lu_rd_data),
        .o_lu_ready      (o_lu_ready),
        .o_rd_addr       (o_rd_addr),
        .o_rd_data       (o_rd_data),
        .o_rd_wren       (o_rd_wren),
        .o_pending       (o_pending),
        .o_err           (o_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_issue_valid    = 1'b0;
        i_issue_rs1_addr = '0;
        i_issue_rs2_addr = '0;
        i_issue_rs1_used = 1'b0;
        i_issue_rs2_used = 1'b0;
        i_issue_rd_addr  = '0;
        i_issue_rd_wren  = 1'b0;
        i_issue_long     = 1'b0;
        i_wb_valid       = 1'b0;
        i_wb_rd_addr     = '0;
        i_wb_rd_data     = '0;
        i_lu_valid       = 1'b0;
        i_lu_rd_addr     = '0;
        i_lu_rd_data     = '0;
    endtask

    // Step just past the next rising edge; inputs are then driven and checked at +1.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        idle();
        i_issue_valid   = 1'b1;
        i_issue_rd_addr = rd;
        i_issue_rd_wren = 1'b1;
        i_issue_long    = 1'b1;
    endtask

    initial begin
        idle();
        i_reset = 1'b1;
        #2;
        check_eq("rst_stall", o_issue_stall, 0);
        check_eq("rst_lu_ready", o_lu_ready, 0);
        check_eq("rst_wren", o_rd_wren, 0);
        check_eq("rst_pending", o_pending, 0);
        check_eq("rst_err", o_err, 0);
        #20 i_reset = 1'b0;

        // RAW on a long op
        tick();
        issue_long(5'd5);
        #1 check_eq("raw_long_issue", o_issue_stall, 0);
        tick();
        idle();
        i_issue_valid    = 1'b1;
        i_issue_rs1_addr = 5'd5;
        i_issue_rs1_used = 1'b1;
        i_issue_rd_addr  = 5'd6;
        i_issue_rd_wren  = 1'b1;
        #1 check_eq("raw_pending", o_pending, 32'h0000_0020);
        for (int k = 0; k < 3; k++) begin
            check_eq("raw_stall_wait", o_issue_stall, 1);
            tick();
        end
        i_lu_valid   = 1'b1;
        i_lu_rd_addr = 5'd5;
        i_lu_rd_data = 32'hDEAD_BEEF;
        #1;
        check_eq("raw_lu_ready", o_lu_ready, 1);
        check_eq("raw_wren", o_rd_wren, 1);
        check_eq("raw_addr", o_rd_addr, 5);
        check_eq("raw_data", o_rd_data, 32'hDEAD_BEEF);
`ifdef RF_SB_CLEAR_BYPASS_EN
        check_eq("raw_grant_stall", o_issue_stall, 0);
`else
        check_eq("raw_grant_stall", o_issue_stall, 1);
`endif
        tick();
        i_lu_valid = 1'b0;
        #1;
        check_eq("raw_after_stall", o_issue_stall, 0);
        check_eq("raw_after_pending", o_pending, 0);

        // Port conflict: WB x3 beats LU x7
        tick();
        issue_long(5'd7);
        tick();
        idle();
        i_wb_valid   = 1'b1;
        i_wb_rd_addr = 5'd3;
        i_wb_rd_data = 32'h0000_0033;
        i_lu_valid   = 1'b1;
        i_lu_rd_addr = 5'd7;
        i_lu_rd_data = 32'h0000_0077;
        #1;
        check_eq("conf_wb_addr", o_rd_addr, 3);
        check_eq("conf_wb_data", o_rd_data, 32'h33);
        check_eq("conf_wb_wren", o_rd_wren, 1);
        check_eq("conf_lu_held", o_lu_ready, 0);
        tick();
        i_wb_valid = 1'b0;
        #1;
        check_eq("conf_lu_ready", o_lu_ready, 1);
        check_eq("conf_lu_addr", o_rd_addr, 7);
        check_eq("conf_lu_data", o_rd_data, 32'h77);
        tick();
        i_lu_valid = 1'b0;
        #1;
        check_eq("conf_pending", o_pending, 0);
        check_eq("conf_err", o_err, 0);

        // Starvation: continuous WB, LU waiting on x10
        tick();
        issue_long(5'd10);
        tick();
        idle();
        i_issue_valid    = 1'b1;
        i_issue_rs1_addr = 5'd2;
        i_issue_rs1_used = 1'b1;
        i_issue_rd_addr  = 5'd11;
        i_issue_rd_wren  = 1'b1;
        i_wb_valid       = 1'b1;
        i_wb_rd_addr     = 5'd1;
        i_wb_rd_data     = 32'h1111;
        i_lu_valid       = 1'b1;
        i_lu_rd_addr     = 5'd10;
        i_lu_rd_data     = 32'hAAAA;
        for (int k = 0; k < 4; k++) begin
            #1 check_eq("starve_no_stall", o_issue_stall, 0);
            tick();
        end
        #1 check_eq("starve_stall", o_issue_stall, 1);
        tick();
        #1 check_eq("starve_stall_sat", o_issue_stall, 1);
        i_wb_valid = 1'b0;
        #1;
        check_eq("starve_grant", o_lu_ready, 1);
        check_eq("starve_grant_addr", o_rd_addr, 10);
        tick();
        i_lu_valid = 1'b0;
        #1;
        check_eq("starve_cleared", o_issue_stall, 0);
        check_eq("starve_pending", o_pending, 0);

        // x0 and WAW
        tick();
        issue_long(5'd9);
        tick();
        idle();
        i_issue_valid   = 1'b1;
        i_issue_rd_addr = 5'd9;
        i_issue_rd_wren = 1'b1;
        #1 check_eq("waw_stall", o_issue_stall, 1);
        tick();
        idle();
        i_wb_valid   = 1'b1;
        i_wb_rd_addr = 5'd0;
        i_lu_valid   = 1'b1;
        i_lu_rd_addr = 5'd9;
        i_lu_rd_data = 32'h9999;
        #1;
        check_eq("x0_wb_lu_ready", o_lu_ready, 1);
        check_eq("x0_wb_lu_addr", o_rd_addr, 9);
        tick();
        issue_long(5'd0);
        i_issue_rs1_used = 1'b1;
        #1 check_eq("x0_long_stall", o_issue_stall, 0);
        tick();
        idle();
        #1 check_eq("x0_long_pending", o_pending, 0);

        // Error flag on unexpected LU write
        i_lu_valid   = 1'b1;
        i_lu_rd_addr = 5'd12;
        i_lu_rd_data = 32'h1212;
        #1 check_eq("err_pre", o_err, 0);
        tick();
        idle();
        #1 check_eq("err_set", o_err, 1);
        tick();
        tick();
        check_eq("err_sticky", o_err, 1);

        // Async reset mid-operation: pending=0x20, counter=3
        issue_long(5'd5);
        tick();
        idle();
        i_wb_valid   = 1'b1;
        i_wb_rd_addr = 5'd1;
        i_lu_valid   = 1'b1;
        i_lu_rd_addr = 5'd5;
        tick();
        tick();
        tick();
        check_eq("mid_pending", o_pending, 32'h0000_0020);
        #2 i_reset = 1'b1;
        #1;
        check_eq("mid_rst_pending", o_pending, 0);
        check_eq("mid_rst_stall", o_issue_stall, 0);
        check_eq("mid_rst_err", o_err, 0);
        idle();
        tick();
        i_reset = 1'b0;
        i_issue_valid = 1'b1;
        i_wb_valid    = 1'b1;
        i_wb_rd_addr  = 5'd1;
        i_lu_valid    = 1'b1;
        i_lu_rd_addr  = 5'd5;
        tick();
        tick();
        tick();
        // Counter restarted from 0, so three waits must not yet throttle.
        #1 check_eq("mid_cnt_restart", o_issue_stall, 0);
        tick();
        #1 check_eq("mid_cnt_limit", o_issue_stall, 1);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wb_scoreboard.md
Name: rf_wb_scoreboard

Overview:
- Controls the regfile's single write port and sequences instruction issue around it.
- Keeps a per-register pending scoreboard for long-latency ops (mul/div, multi-cycle load). Stalls issue on RAW/WAW hazards against pending registers.
- Arbitrates the write port between in-order pipeline writeback (WB) and the long-latency unit (LU). Sits between the decode/issue stage, the WB stage and the regfile write inputs.

Parameters:
- STARVE_LIMIT, 4: LU wait cycles before issue is throttled so that WB bubbles free the port; legal range 1..15.
- XLEN, 32: data width.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high
- i_issue_valid  in  1  decode stage holds a valid instruction
- i_issue_rs1_addr  in  5  source 1
- i_issue_rs2_addr  in  5  source 2
- i_issue_rs1_used  in  1  rs1 is read
- i_issue_rs2_used  in  1  rs2 is read
- i_issue_rd_addr  in  5  destination
- i_issue_rd_wren  in  1  instruction writes rd
- i_issue_long  in  1  instruction goes to LU
- o_issue_stall  out  1  hold decode; the instruction does not issue this cycle
- i_wb_valid  in  1  WB write request; cannot be back-pressured
- i_wb_rd_addr  in  5  WB destination
- i_wb_rd_data  in  XLEN  WB data
- i_lu_valid  in  1  LU write request
- i_lu_rd_addr  in  5  LU destination
- i_lu_rd_data  in  XLEN  LU data
- o_lu_ready  out  1  LU write accepted this cycle
- o_rd_addr  out  5  to regfile i_rd_addr
- o_rd_data  out  XLEN  to regfile i_rd_data
- o_rd_wren  out  1  to regfile i_rd_wren
- o_pending  out  32  scoreboard bits, one per register
- o_err  out  1  sticky: LU wrote a register that was not pending

Behaviour:
- Reset (async): pending=0, wait counter=0, o_err=0.
  - Combinational outputs therefore settle to o_issue_stall=0, o_lu_ready=0 and o_rd_wren=0 when no requests are present.
  - Reset mid-operation drops all pending bits; the LU is reset by the same i_reset.
- Write-port arbitration (combinational, zero latency):
  - WB request is effective when i_wb_valid=1 and i_wb_rd_addr!=0.
  - Effective WB request: WB drives o_rd_*, o_rd_wren=1, o_lu_ready=0.
  - Otherwise, if i_lu_valid=1: LU drives o_rd_*, o_lu_ready=1, and o_rd_wren=(i_lu_rd_addr!=0).
  - Otherwise: o_rd_wren=0, o_rd_addr=0, o_rd_data=0.
  - x0 is never written.
- LU handshake: once i_lu_valid rises, LU holds addr/data stable until it samples o_lu_ready=1 at a clock edge.
- Starvation counter (4-bit):
  - Increments each cycle i_lu_valid=1 and o_lu_ready=0, saturating at STARVE_LIMIT.
  - Clears on an LU grant or when i_lu_valid=0.
  - Counter==STARVE_LIMIT forces o_issue_stall=1. The bubble reaches WB after the pipeline drains and the LU is then granted.
- Hazard stall (uses registered pending, no same-cycle clear bypass). o_issue_stall=1 when i_issue_valid and any of:
  - rs1_used and pending[rs1];
  - rs2_used and pending[rs2];
  - rd_wren and pending[rd] (WAW);
  - starvation throttle active.
- Register 0 is never pending, and reading or writing x0 never stalls.
- Scoreboard update at clock edge:
  - Set pending[rd] when i_issue_valid, !o_issue_stall, i_issue_long, i_issue_rd_wren and rd!=0.
  - Clear pending[i_lu_rd_addr] on an LU grant.
  - Same register set and cleared in one cycle: set wins.
- o_err sets when an LU grant targets a register with pending=0 and rd!=0. It is cleared only by reset.

Optional Feature:
- Macro: RF_SB_CLEAR_BYPASS_EN.
- Defined: the hazard check masks pending[i_lu_rd_addr] in the cycle that LU is granted. A dependent instruction issues in the same cycle as the write. This relies on the regfile's same-cycle rd-to-rs forwarding.
- Undefined: a dependent instruction stalls through the grant cycle and issues one cycle later.

Decomposition:
- Package rf_pkg:
  - constants NUM_REGS=32, REG_ADDR_W=5, XLEN_DEF=32;
  - typedef reg_addr_t (logic[4:0]);
  - typedef rf_wr_req_t struct {valid, addr, data}.
- Sub-module rf_wb_arbiter: write-port mux plus starvation counter. It outputs grant signals and the throttle flag.
- The top module holds the scoreboard, the hazard logic and o_err.

Test Plan:
- Reset while pending=0x0000_0020 and counter=3 -> pending=0, counter=0, o_issue_stall=0, o_err=0 immediately (async).
- RAW on long op:
  - Stimulus: issue long op rd=5, then add rs1=5; LU valid rd=5 data=0xDEADBEEF four cycles later with WB idle.
  - Response: add stalls until the grant cycle, o_rd_wren=1, addr=5, data=0xDEADBEEF.
  - Add issues one cycle after the grant; with RF_SB_CLEAR_BYPASS_EN it issues in the grant cycle.
- Port conflict: WB rd=3 and LU rd=7 valid in the same cycle -> WB writes x3, o_lu_ready=0, LU held; next cycle with WB idle, x7 is written.
- Starvation with STARVE_LIMIT=4: WB valid every cycle and LU valid -> o_issue_stall rises after 4 waiting cycles; LU is granted on the first WB bubble and the counter returns to 0.
- x0 and WAW:
  - WB rd=0 with LU valid rd=9 -> LU is granted.
  - Long op with rd=0 -> no pending bit is set.
  - Second write to pending x9 -> stalls.
- Error flag: LU grant to rd=12 with pending[12]=0 -> o_err=1 and stays set until reset.
